// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS test data-memory model.
// Feature macro: DATA_RAM_RANDOM_STALL_EN (random extra wait cycles).
package mips_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  byteen_t;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mips_mem_wait_ctrl.sv
// Wait-state controller: IDLE/BUSY FSM, wait counter, optional stall LFSR.
// Feature macro: DATA_RAM_RANDOM_STALL_EN.
module mips_mem_wait_ctrl
  import mips_mem_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic req_i,
  output logic waitrequest_o,
  output logic complete_o
);

  localparam int CW = $clog2(LATENCY + 8) + 1;
  typedef logic [CW-1:0] cnt_t;

  mem_state_e state_q;
  cnt_t       cnt_q;
  cnt_t       total;
  logic [2:0] extra;
  logic       done;

`ifdef DATA_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]}
              ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    end
  end

  assign extra = lfsr_q[2:0];
`else
  assign extra = 3'd0;
`endif

  assign total = cnt_t'(LATENCY) + cnt_t'(extra);

  // A zero total completes straight out of IDLE.
  always_comb begin
    done = 1'b0;
    unique case (state_q)
      IDLE:    done = (total == '0);
      BUSY:    done = (cnt_q == '0);
      default: done = 1'b0;
    endcase
  end

  assign complete_o    = reset_n_i & req_i & done;
  assign waitrequest_o = ~reset_n_i | (req_i & ~done);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i && !done) begin
            state_q <= BUSY;
            cnt_q   <= total - cnt_t'(1);
          end
        end
        BUSY: begin
          if (!req_i || done) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mips_data_ram_wait.sv
// Parametrised MIPS data-memory model with waitrequest handshake.
// Feature macro: DATA_RAM_RANDOM_STALL_EN (random extra wait cycles).
module mips_data_ram_wait
  import mips_mem_pkg::*;
#(
  parameter int    ADDR_W     = 12,
  parameter int    LATENCY    = 0,
  parameter string INIT_FILE  = "",
  parameter int    INIT_COUNT = 30,
  parameter word_t INIT_BASE  = 32'h12345678,
  parameter word_t INIT_STEP  = 32'hdcba1234
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic        data_waitrequest,
  output logic [31:0] data_readdata,
  output logic        data_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  typedef word_t mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t  m;
    word_t v;
    v = INIT_BASE;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_FILE == "" && i < INIT_COUNT) ? v : '0;
      v    = v + INIT_STEP;
    end
    return m;
  endfunction

  mem_t mem_q = init_mem();

  logic              req;
  logic              done;
  logic              err_c;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr;

  assign req         = data_read | data_write;
  assign idx         = data_address[ADDR_W+1:2];
  assign unused_addr = ^data_address[31:ADDR_W+2];
  assign err_c       = (data_address[1:0] != 2'b00)
                     | (data_read & data_write);

  mips_mem_wait_ctrl #(
    .LATENCY(LATENCY)
  ) u_ctrl (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_i        (req),
    .waitrequest_o(data_waitrequest),
    .complete_o   (done)
  );

  assign data_err      = done & err_c;
  assign data_readdata = (done & data_read & ~err_c)
                       ? mem_q[idx] : '0;

  always_ff @(posedge clk) begin
    if (done && data_write && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (data_byteenable[b]) begin
          mem_q[idx][8*b +: 8] <= data_writedata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_data_ram_wait.sv
// Self-checking bench: three RAM instances (LATENCY 0/3/2), vector table,
// hand sequences for reset/abort, random traffic vs. a word-array model.
module tb_mips_data_ram_wait;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  rd_v;
  logic [2:0]  wr_v;
  logic [31:0] addr;
  word_t       wdata;
  byteen_t     be;
  logic [2:0]  wt_v;
  logic [2:0]  err_v;
  word_t       rdat [3];

  int checks = 0;
  int errors = 0;
  int lat [3] = '{0, 3, 2};

  word_t model [3][4096];

  mips_data_ram_wait #(.ADDR_W(12), .LATENCY(0)) u0 (
    .clk(clk), .reset_n(rst_n[0]), .data_address(addr),
    .data_write(wr_v[0]), .data_read(rd_v[0]),
    .data_writedata(wdata), .data_byteenable(be),
    .data_waitrequest(wt_v[0]), .data_readdata(rdat[0]),
    .data_err(err_v[0]));

  mips_data_ram_wait #(.ADDR_W(12), .LATENCY(3)) u1 (
    .clk(clk), .reset_n(rst_n[1]), .data_address(addr),
    .data_write(wr_v[1]), .data_read(rd_v[1]),
    .data_writedata(wdata), .data_byteenable(be),
    .data_waitrequest(wt_v[1]), .data_readdata(rdat[1]),
    .data_err(err_v[1]));

  mips_data_ram_wait #(.ADDR_W(12), .LATENCY(2)) u2 (
    .clk(clk), .reset_n(rst_n[2]), .data_address(addr),
    .data_write(wr_v[2]), .data_read(rd_v[2]),
    .data_writedata(wdata), .data_byteenable(be),
    .data_waitrequest(wt_v[2]), .data_readdata(rdat[2]),
    .data_err(err_v[2]));

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wait(input string name, input int k, input int w);
    bit ok;
`ifdef DATA_RAM_RANDOM_STALL_EN
    ok = (w >= lat[k]) && (w <= lat[k] + 7);
`else
    ok = (w == lat[k]);
`endif
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: waits %0d, latency %0d", name, w, lat[k]);
    end
  endtask

  // Reference: word array, error rule, byte-lane merge.
  task automatic mdl(input int k, input logic r, input logic w,
                     input logic [31:0] a, input word_t d,
                     input byteen_t b, output word_t q,
                     output logic e);
    int i;
    i = int'(a[13:2]);
    e = (a[1:0] != 2'b00) || (r && w);
    q = (!e && r) ? model[k][i] : 32'h0;
    if (!e && w) begin
      for (int n = 0; n < 4; n++) begin
        if (b[n]) model[k][i][8*n +: 8] = d[8*n +: 8];
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after completion.
  task automatic access(input int k, input logic r, input logic w,
                        input logic [31:0] a, input word_t d,
                        input byteen_t b, output word_t q,
                        output logic e, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    q     = '0;
    e     = 1'b0;
    addr  = a;
    wdata = d;
    be    = b;
    rd_v[k] = r;
    wr_v[k] = w;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!wt_v[k]) begin
        q    = rdat[k];
        e    = err_v[k];
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout inst %0d addr %h: no completion", k, a);
    end
  endtask

  typedef struct {
    int          k;
    logic        r;
    logic        w;
    logic [31:0] a;
    word_t       d;
    byteen_t     b;
    word_t       xq;
    logic        xe;
  } vec_t;

  vec_t tbl [13];

  initial begin
    word_t q, mq;
    logic  e, me;
    int    w;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4096; i++) begin
        model[k][i] = (i < 30)
          ? 32'h12345678 + 32'(i) * 32'hdcba1234 : 32'h0;
      end
    end

    tbl[0]  = '{0, 1, 0, 32'h08,   32'h0,        4'hf, 32'hCBA87AE0, 0};
    tbl[1]  = '{0, 0, 1, 32'h10,   32'hAABBCCDD, 4'h5, 32'h0,        0};
    tbl[2]  = '{0, 1, 0, 32'h10,   32'h0,        4'hf, 32'h85BB9FDD, 0};
    tbl[3]  = '{1, 1, 0, 32'h04,   32'h0,        4'hf, 32'hEEEE68AC, 0};
    tbl[4]  = '{1, 0, 1, 32'h06,   32'hFFFFFFFF, 4'hf, 32'h0,        1};
    tbl[5]  = '{1, 1, 0, 32'h04,   32'h0,        4'hf, 32'hEEEE68AC, 0};
    tbl[6]  = '{1, 1, 1, 32'h00,   32'h0,        4'hf, 32'h0,        1};
    tbl[7]  = '{1, 0, 1, 32'h10,   32'hAABBCCDD, 4'h5, 32'h0,        0};
    tbl[8]  = '{1, 1, 0, 32'h10,   32'h0,        4'hf, 32'h85BB9FDD, 0};
    tbl[9]  = '{0, 0, 1, 32'h08,   32'h0,        4'h0, 32'h0,        0};
    tbl[10] = '{0, 1, 0, 32'h08,   32'h0,        4'hf, 32'hCBA87AE0, 0};
    tbl[11] = '{0, 1, 0, 32'h4000, 32'h0,        4'hf, 32'h12345678, 0};
    tbl[12] = '{2, 1, 0, 32'h09,   32'h0,        4'hf, 32'h0,        1};

    // Reset state with a read held on every instance.
    rst_n = 3'b000;
    rd_v  = 3'b111;
    wr_v  = 3'b000;
    addr  = 32'h08;
    wdata = '0;
    be    = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_wait%0d", k), {31'b0, wt_v[k]}, 32'h1);
      chk($sformatf("rst_rdata%0d", k), rdat[k], 32'h0);
      chk($sformatf("rst_err%0d", k), {31'b0, err_v[k]}, 32'h0);
    end
    @(posedge clk);
    #1;
    rd_v  = 3'b000;
    rst_n = 3'b111;
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++) begin
      access(tbl[v].k, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d,
             tbl[v].b, q, e, w);
      mdl(tbl[v].k, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d,
          tbl[v].b, mq, me);
      chk($sformatf("vec%0d_rdata", v), q, tbl[v].xq);
      chk($sformatf("vec%0d_err", v), {31'b0, e}, {31'b0, tbl[v].xe});
      chk_wait($sformatf("vec%0d_wait", v), tbl[v].k, w);
    end

    // Reset lands in the middle of a pending write: nothing commits.
    addr    = 32'h0;
    wdata   = 32'h11111111;
    be      = 4'hf;
    wr_v[1] = 1'b1;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_wait", {31'b0, wt_v[1]}, 32'h1);
    chk("rstmid_rdata", rdat[1], 32'h0);
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    wr_v[1]  = 1'b0;
    access(1, 1, 0, 32'h0, 32'h0, 4'hf, q, e, w);
    chk("rstmid_read", q, 32'h12345678);
    chk_wait("rstmid_read_wait", 1, w);

    // Request withdrawn while busy: aborted, no write.
    wdata   = 32'h22222222;
    wr_v[1] = 1'b1;
    @(posedge clk);
    #1;
    wr_v[1] = 1'b0;
    @(posedge clk);
    #1;
    access(1, 1, 0, 32'h0, 32'h0, 4'hf, q, e, w);
    chk("drop_read", q, 32'h12345678);
    chk_wait("drop_read_wait", 1, w);

    // Random traffic against the model, instance 2 weighted heaviest.
    for (int n = 0; n < 220; n++) begin
      int          k, op;
      logic        r, wr;
      logic [31:0] a;
      word_t       d;
      byteen_t     b;
      k  = (n < 60) ? 0 : (n < 120) ? 1 : 2;
      op = int'($urandom_range(0, 9));
      r  = (op <= 4);
      wr = (op == 0) || (op >= 5);
      a  = ($urandom() & 32'hFFFF_C000)
         | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d  = $urandom();
      b  = 4'($urandom_range(0, 15));
      access(k, r, wr, a, d, b, q, e, w);
      mdl(k, r, wr, a, d, b, mq, me);
      chk($sformatf("rnd%0d_rdata", n), q, mq);
      chk($sformatf("rnd%0d_err", n), {31'b0, e}, {31'b0, me});
      chk_wait($sformatf("rnd%0d_wait", n), k, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
